// File: rtl/sid_pkg.sv
// Shared types for the SID bus writer: bus widths, FSM state and queued write entry.
package sid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } sid_state_e;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_wr_entry_t;

endpackage

// File: rtl/sid_bus_writer_if.sv
// Write-request and SID bus signals of sid_bus_writer.
// With SID_OVF_FLAG_EN defined the interface also carries the sticky wr_ovf flag.
interface sid_bus_writer_if;
  import sid_pkg::*;

  logic                  wr_en;
  logic [SID_ADDR_W-1:0] wr_addr;
  logic [SID_DATA_W-1:0] wr_data;
  logic                  wr_full;
  logic                  busy;
  logic                  sid_clk;
  logic [SID_ADDR_W-1:0] sid_addr;
  logic [SID_DATA_W-1:0] sid_data;
  logic                  sid_cs_n;
  logic                  sid_rw;
`ifdef SID_OVF_FLAG_EN
  logic                  wr_ovf;

  modport master (
    input  wr_en, wr_addr, wr_data,
    output wr_full, busy, sid_clk, sid_addr, sid_data, sid_cs_n, sid_rw, wr_ovf
  );

  modport slave (
    output wr_en, wr_addr, wr_data,
    input  wr_full, busy, sid_clk, sid_addr, sid_data, sid_cs_n, sid_rw, wr_ovf
  );
`else
  modport master (
    input  wr_en, wr_addr, wr_data,
    output wr_full, busy, sid_clk, sid_addr, sid_data, sid_cs_n, sid_rw
  );

  modport slave (
    output wr_en, wr_addr, wr_data,
    input  wr_full, busy, sid_clk, sid_addr, sid_data, sid_cs_n, sid_rw
  );
`endif

endinterface

// File: rtl/sid_wr_fifo.sv
// Small show-ahead write queue: the head entry is visible before it is popped,
// so the bus FSM can load it on the same edge as the pop.
module sid_wr_fifo
  import sid_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  sid_wr_entry_t wr_entry,
  output sid_wr_entry_t rd_entry,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sid_wr_entry_t mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          push_ok;
  logic          pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_entry = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sid_bus_writer.sv
// Queues register writes and replays each as a SID bus write cycle aligned to sid_clk.
// Define SID_OVF_FLAG_EN to add a sticky wr_ovf flag that records dropped pushes.
module sid_bus_writer
  import sid_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sid_bus_writer_if.master  bus
);

  localparam int             CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic                  sid_clk_reg;
  sid_state_e            state_reg;
  logic                  cs_n_reg;
  logic                  rw_reg;
  logic [SID_ADDR_W-1:0] addr_reg;
  logic [SID_DATA_W-1:0] data_reg;

  sid_wr_entry_t         push_entry;
  sid_wr_entry_t         head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign push_entry = '{addr: bus.wr_addr, data: bus.wr_data};
  assign fifo_pop   = (state_reg == IDLE) && (cnt_reg == CNT_LAST) && !fifo_empty;

  sid_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.wr_en),
    .pop      (fifo_pop),
    .wr_entry (push_entry),
    .rd_entry (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
  end

  // sid_clk is derived from the next count so it stays in lockstep with cnt_reg.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg     <= '0;
      sid_clk_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      sid_clk_reg <= (cnt_next >= HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cs_n_reg  <= 1'b1;
      rw_reg    <= 1'b1;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_pop) begin
            state_reg <= SETUP;
            addr_reg  <= head_entry.addr;
            data_reg  <= head_entry.data;
            rw_reg    <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_reg == HALF_LAST) begin
            state_reg <= STROBE;
            cs_n_reg  <= 1'b0;
          end
        end
        STROBE: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= HOLD;
            cs_n_reg  <= 1'b1;
          end
        end
        HOLD: begin
          // One clock of address/data/rw hold after chip select deasserts.
          state_reg <= IDLE;
          rw_reg    <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          cs_n_reg  <= 1'b1;
          rw_reg    <= 1'b1;
        end
      endcase
    end
  end

`ifdef SID_OVF_FLAG_EN
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      ovf_reg <= 1'b1;
    end
  end

  assign bus.wr_ovf = ovf_reg;
`endif

  assign bus.wr_full  = fifo_full;
  assign bus.busy     = !fifo_empty || (state_reg != IDLE);
  assign bus.sid_clk  = sid_clk_reg;
  assign bus.sid_addr = addr_reg;
  assign bus.sid_data = data_reg;
  assign bus.sid_cs_n = cs_n_reg;
  assign bus.sid_rw   = rw_reg;

endmodule

// File: doc/sid_bus_writer.md
Name: sid_bus_writer

Overview:
- Downstream of the SPI register-write stage: accepts (addr, data) register writes, queues them, and replays each as a genuine write cycle on the physical SID bus.
- Generates the SID phase clock `sid_clk` by dividing `clk`.
- Aligns every chip-select strobe to a `sid_clk` high phase, so bursty SPI traffic is decoupled from the fixed SID bus rate.

Parameters:
- CLK_DIV, 16: `clk` cycles per `sid_clk` period. Even, ≥4.
- FIFO_DEPTH, 4: write-queue entries. Power of 2, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-low (0 = reset), sampled on `clk` rising edge
- wr_en  in  1  one-cycle push request from the SPI stage
- wr_addr  in  5  SID register address
- wr_data  in  8  SID register data
- wr_full  out  1  FIFO full; a push while high is dropped
- busy  out  1  FIFO non-empty or bus cycle in progress
- sid_clk  out  1  SID phase clock (registered)
- sid_addr  out  5  SID address bus
- sid_data  out  8  SID data bus (write only)
- sid_cs_n  out  1  SID chip select, active low
- sid_rw  out  1  1 = read/idle, 0 = write

Behaviour:
- Reset (rst=0 at a `clk` edge): values take effect on that edge, regardless of current state.
  - div counter = 0, sid_clk = 0, sid_cs_n = 1, sid_rw = 1, sid_addr = 0, sid_data = 0.
  - FIFO empty, wr_full = 0, busy = 0, FSM in IDLE.
- Divider:
  - cnt counts 0..CLK_DIV-1 and wraps.
  - sid_clk = 0 while cnt < CLK_DIV/2, else 1, so the duty cycle is exactly 50%.
  - Free-running whenever out of reset.
- FIFO:
  - Push when wr_en=1 and wr_full=0. A push while full is dropped, even if a pop occurs in the same cycle.
  - Pop happens only in the FSM IDLE→SETUP transition.
  - Order is FIFO; wr_addr and wr_data are passed through unmodified, with no range check.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: sid_cs_n = 1, sid_rw = 1. If cnt == CLK_DIV-1 and the FIFO is non-empty, pop → SETUP. Outputs take effect as cnt wraps to 0, at the `sid_clk` falling edge:
    - sid_addr and sid_data load the popped entry;
    - sid_rw = 0.
  - SETUP: bus stable through the `sid_clk` low phase. When cnt == CLK_DIV/2-1, go to STROBE; sid_cs_n = 0 from the edge where sid_clk rises.
  - STROBE: sid_cs_n held low for exactly CLK_DIV/2 clocks, the whole high phase. When cnt == CLK_DIV-1, go to HOLD; sid_cs_n = 1 together with the `sid_clk` fall.
  - HOLD: sid_addr, sid_data and sid_rw = 0 held for 1 more clock (hold time), then sid_rw = 1 → IDLE. sid_addr and sid_data keep their last value while idle.
- Throughput: at most one bus write per 2 sid_clk periods.
- Latency: a push in an empty, idle block reaches sid_cs_n = 0 between CLK_DIV/2+1 and 3·CLK_DIV/2 clocks later.
- busy = FIFO non-empty OR state ≠ IDLE.

Optional Feature:
- SID_OVF_FLAG_EN defined:
  - adds output `wr_ovf` (1 bit), reset 0;
  - `wr_ovf` is set on any dropped push and stays set until reset.
- Undefined: the port is absent and drops are silent.

Decomposition:
- Shared package sid_pkg:
  - SID_ADDR_W = 5, SID_DATA_W = 8;
  - state typedef {IDLE, SETUP, STROBE, HOLD};
  - packed write-entry struct {addr, data}.
- One sub-module, sid_wr_fifo: synchronous FIFO with push/pop, full/empty and parameter FIFO_DEPTH, same clock and reset.

Test Plan (CLK_DIV=16, FIFO_DEPTH=4):
- Reset: hold rst=0 for 3 clocks → sid_cs_n=1, sid_rw=1, sid_addr=0, sid_data=0, sid_clk=0, busy=0, wr_full=0.
- Divider: no writes, 64 clocks → sid_clk period 16 clocks, high 8, low 8, first rise 8 clocks after reset release.
- Single write: push addr=0x18, data=0x0F.
  - sid_addr=0x18, sid_data=0x0F and sid_rw=0 appear at the next cnt wrap.
  - sid_cs_n is low for exactly 8 clocks, coincident with sid_clk=1.
  - sid_rw returns to 1 one clock after sid_cs_n rises.
- Overflow: 5 back-to-back pushes (0x00/0xA1, 0x01/0xA2, 0x02/0xA3, 0x03/0xA4, 0x04/0xA5), starting at cnt=0.
  - wr_full=1 after the 4th push; the 5th push is dropped.
  - Exactly 4 bus writes follow, in order, strobes 32 clocks apart.
  - With SID_OVF_FLAG_EN defined, wr_ovf=1.
- Reset mid-strobe: rst=0 while sid_cs_n=0 with 2 entries queued.
  - Next clock: sid_cs_n=1, sid_rw=1, busy=0.
  - After release, no further bus cycles occur.
- Full+pop same cycle: FIFO full and popped on the same edge as wr_en=1 → that push is dropped; wr_full=0 one clock later.
